// File: rtl/pci_master_fsm_if.sv
// Local request port and PCI initiator bus for pci_master_fsm.
// AD_in is the value the target places on AD during read data phases.
interface pci_master_fsm_if #(
  parameter int LEN_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cmd;
  logic [31:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [31:0]      wdata;
  logic [3:0]       wbe;
  logic             wdata_adv;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             done;
  logic             err;
  logic             FRAME_;
  logic             IRDY_;
  logic             TRDY_;
  logic             DEVSEL_;
  logic [31:0]      AD;
  logic [31:0]      AD_in;
  logic             ad_oe;
  logic [3:0]       C_BE_;

  modport master (
    input  req_valid, req_cmd, req_addr,
    input  req_len, wdata, wbe,
    input  TRDY_, DEVSEL_, AD_in,
    output req_ready, wdata_adv,
    output rd_data, rd_valid, done, err,
    output FRAME_, IRDY_, AD, ad_oe, C_BE_
  );

  modport slave (
    output req_valid, req_cmd, req_addr,
    output req_len, wdata, wbe,
    output TRDY_, DEVSEL_, AD_in,
    input  req_ready, wdata_adv,
    input  rd_data, rd_valid, done, err,
    input  FRAME_, IRDY_, AD, ad_oe, C_BE_
  );
endinterface

// File: rtl/pci_master_fsm.sv
// PCI initiator: address phase, TRDY_-paced data phases, turnaround,
// and master abort when DEVSEL_ never asserts.
module pci_master_fsm #(
  parameter int LEN_W     = 8,
  parameter int DEVSEL_TO = 5
) (
  input  logic clk,
  input  logic reset_,
  pci_master_fsm_if.master bus
);

  localparam int TW = $clog2(DEVSEL_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ABORT,
    S_TURN
  } state_t;

  state_t           r_state, w_state;
  logic             r_write, w_write;
  logic [LEN_W-1:0] r_rem, w_rem;
  logic [TW-1:0]    r_tmr, w_tmr;
  logic             r_dsel, w_dsel;
  logic             r_frame_n, w_frame_n;
  logic             r_irdy_n, w_irdy_n;
  logic [31:0]      r_ad, w_ad;
  logic             r_ad_oe, w_ad_oe;
  logic [3:0]       r_cbe, w_cbe;
  logic [31:0]      r_rd_data, w_rd_data;
  logic             r_rd_valid, w_rd_valid;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             w_beat;
  logic             w_to;

  assign w_beat = (r_state == S_DATA)
                && !r_irdy_n && !bus.TRDY_;

  always_comb begin
    w_state    = r_state;
    w_write    = r_write;
    w_rem      = r_rem;
    w_tmr      = r_tmr;
    w_dsel     = r_dsel;
    w_frame_n  = r_frame_n;
    w_irdy_n   = r_irdy_n;
    w_ad       = r_ad;
    w_ad_oe    = r_ad_oe;
    w_cbe      = r_cbe;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_to       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state   = S_ADDR;
          w_write   = bus.req_cmd[0];
          w_rem     = (bus.req_len == '0)
                    ? LEN_W'(1) : bus.req_len;
          w_tmr     = '0;
          w_dsel    = 1'b0;
          w_frame_n = 1'b0;
          w_irdy_n  = 1'b1;
          w_ad      = bus.req_addr;
          w_cbe     = bus.req_cmd;
          w_ad_oe   = 1'b1;
        end
      end
      S_ADDR: begin
        w_state   = S_DATA;
        w_tmr     = '0;
        w_dsel    = 1'b0;
        w_irdy_n  = 1'b0;
        w_frame_n = (r_rem == LEN_W'(1));
        w_cbe     = bus.wbe;
        w_ad      = r_write ? bus.wdata : '0;
        w_ad_oe   = r_write;
      end
      S_DATA: begin
        // timer saturates so a late non-beat cycle still aborts
        if (!bus.DEVSEL_) begin
          w_dsel = 1'b1;
        end else if (!r_dsel
                     && r_tmr != TW'(DEVSEL_TO)) begin
          w_tmr = r_tmr + TW'(1);
        end
        w_to = !r_dsel && bus.DEVSEL_
             && (w_tmr == TW'(DEVSEL_TO));
        if (w_beat) begin
          if (!r_write) begin
            w_rd_data  = bus.AD_in;
            w_rd_valid = 1'b1;
          end
          if (r_rem == LEN_W'(1)) begin
            w_state   = S_TURN;
            w_frame_n = 1'b1;
            w_irdy_n  = 1'b1;
            w_ad_oe   = 1'b0;
            w_cbe     = 4'hF;
            w_ad      = '0;
            w_done    = 1'b1;
          end else begin
            w_rem     = r_rem - LEN_W'(1);
            w_frame_n = (r_rem == LEN_W'(2));
            w_cbe     = bus.wbe;
            w_ad      = r_write ? bus.wdata : '0;
          end
        end else if (w_to) begin
          w_state   = S_ABORT;
          w_frame_n = 1'b1;
          w_irdy_n  = 1'b0;
        end
      end
      S_ABORT: begin
        w_state   = S_TURN;
        w_frame_n = 1'b1;
        w_irdy_n  = 1'b1;
        w_ad_oe   = 1'b0;
        w_cbe     = 4'hF;
        w_ad      = '0;
        w_done    = 1'b1;
        w_err     = 1'b1;
      end
      S_TURN: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_rem      <= '0;
      r_tmr      <= '0;
      r_dsel     <= 1'b0;
      r_frame_n  <= 1'b1;
      r_irdy_n   <= 1'b1;
      r_ad       <= '0;
      r_ad_oe    <= 1'b0;
      r_cbe      <= 4'hF;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_write    <= w_write;
      r_rem      <= w_rem;
      r_tmr      <= w_tmr;
      r_dsel     <= w_dsel;
      r_frame_n  <= w_frame_n;
      r_irdy_n   <= w_irdy_n;
      r_ad       <= w_ad;
      r_ad_oe    <= w_ad_oe;
      r_cbe      <= w_cbe;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  // client must show the following beat while wdata_adv is high
  assign bus.wdata_adv = w_beat && r_write;
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.FRAME_    = r_frame_n;
  assign bus.IRDY_     = r_irdy_n;
  assign bus.AD        = r_ad;
  assign bus.ad_oe     = r_ad_oe;
  assign bus.C_BE_     = r_cbe;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_pci_master_fsm.sv
// Directed bench for pci_master_fsm: write, read with waits, abort,
// zero length, mid-burst reset and back-to-back requests.
module tb_pci_master_fsm;

  logic clk;
  logic reset_;
  int   checks;
  int   errors;
  int   nadv;
  int   ndone;
  int   wbase;
  int   widx;
  int   nd0;
  logic [31:0] wbeats [0:15];

  pci_master_fsm_if #(.LEN_W(8)) bus ();

  pci_master_fsm #(
    .LEN_W(8),
    .DEVSEL_TO(5)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write client: next beat appears while wdata_adv is high
  always_comb begin
    widx = nadv - wbase + (bus.wdata_adv ? 1 : 0);
    bus.wdata = wbeats[widx[3:0]];
  end

  always @(posedge clk) begin
    if (bus.wdata_adv) nadv <= nadv + 1;
    if (bus.done) ndone <= ndone + 1;
  end

  always @(negedge clk) begin
    if (reset_ && (!bus.FRAME_ || !bus.IRDY_)) begin
      checks++;
      assert (!$isunknown({bus.AD, bus.C_BE_}))
      else begin
        errors++;
        $error("FAIL ad_known obs=%h exp=known",
               {bus.AD, bus.C_BE_});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] cmd,
                     input logic [31:0] addr,
                     input logic [7:0] len);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_len   = len;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nadv = 0;
    ndone = 0;
    wbase = 0;
    for (int i = 0; i < 16; i++)
      wbeats[i] = 32'hD000_0000 + 32'(i) * 32'h0101;
    reset_ = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd = 4'h0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.wbe = 4'hF;
    bus.TRDY_ = 1'b1;
    bus.DEVSEL_ = 1'b1;
    bus.AD_in = '0;
    #2 reset_ = 1'b0;
    #1;
    chk1("rst_frame", bus.FRAME_, 1'b1);
    chk1("rst_irdy", bus.IRDY_, 1'b1);
    chk("rst_ad", bus.AD, 32'h0);
    chk1("rst_oe", bus.ad_oe, 1'b0);
    chk("rst_cbe", 32'(bus.C_BE_), 32'hF);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_rdv", bus.rd_valid, 1'b0);
    chk("rst_rdd", bus.rd_data, 32'h0);
    tick();
    tick();
    reset_ = 1'b1;
    tick();
    chk1("rel_ready", bus.req_ready, 1'b1);

    // 1: single-beat write
    wbase = nadv;
    bus.wbe = 4'h5;
    req(4'h7, 32'h1000, 8'd1);
    tick();
    bus.req_valid = 1'b0;
    chk1("t1_a_frame", bus.FRAME_, 1'b0);
    chk1("t1_a_irdy", bus.IRDY_, 1'b1);
    chk("t1_a_ad", bus.AD, 32'h1000);
    chk("t1_a_cbe", 32'(bus.C_BE_), 32'h7);
    chk1("t1_a_oe", bus.ad_oe, 1'b1);
    chk1("t1_a_rdy", bus.req_ready, 1'b0);
    bus.TRDY_ = 1'b0;
    bus.DEVSEL_ = 1'b0;
    tick();
    chk1("t1_d_frame", bus.FRAME_, 1'b1);
    chk1("t1_d_irdy", bus.IRDY_, 1'b0);
    chk("t1_d_ad", bus.AD, 32'hD000_0000);
    chk("t1_d_cbe", 32'(bus.C_BE_), 32'h5);
    chk1("t1_d_adv", bus.wdata_adv, 1'b1);
    tick();
    chk1("t1_t_done", bus.done, 1'b1);
    chk1("t1_t_err", bus.err, 1'b0);
    chk1("t1_t_irdy", bus.IRDY_, 1'b1);
    chk1("t1_t_oe", bus.ad_oe, 1'b0);
    chk("t1_t_cbe", 32'(bus.C_BE_), 32'hF);
    chk("t1_nadv", 32'(nadv - wbase), 32'd1);
    bus.TRDY_ = 1'b1;
    bus.DEVSEL_ = 1'b1;
    tick();
    chk1("t1_i_done", bus.done, 1'b0);
    chk1("t1_i_rdy", bus.req_ready, 1'b1);

    // 2: read of 4 with two wait states on beat 2
    bus.wbe = 4'h0;
    req(4'h6, 32'h2000, 8'd4);
    tick();
    bus.req_valid = 1'b0;
    chk("t2_a_cbe", 32'(bus.C_BE_), 32'h6);
    chk("t2_a_ad", bus.AD, 32'h2000);
    bus.TRDY_ = 1'b0;
    bus.DEVSEL_ = 1'b0;
    bus.AD_in = 32'hA000_0000;
    tick();
    chk1("t2_d0_frame", bus.FRAME_, 1'b0);
    chk1("t2_d0_irdy", bus.IRDY_, 1'b0);
    chk1("t2_d0_oe", bus.ad_oe, 1'b0);
    chk("t2_d0_cbe", 32'(bus.C_BE_), 32'h0);
    tick();
    chk1("t2_b0_v", bus.rd_valid, 1'b1);
    chk("t2_b0_d", bus.rd_data, 32'hA000_0000);
    chk1("t2_b0_frame", bus.FRAME_, 1'b0);
    bus.TRDY_ = 1'b1;
    bus.AD_in = 32'hA111_1111;
    tick();
    chk1("t2_w1_v", bus.rd_valid, 1'b0);
    chk1("t2_w1_irdy", bus.IRDY_, 1'b0);
    tick();
    chk1("t2_w2_v", bus.rd_valid, 1'b0);
    chk1("t2_w2_frame", bus.FRAME_, 1'b0);
    bus.TRDY_ = 1'b0;
    tick();
    chk1("t2_b1_v", bus.rd_valid, 1'b1);
    chk("t2_b1_d", bus.rd_data, 32'hA111_1111);
    chk1("t2_b1_frame", bus.FRAME_, 1'b0);
    bus.AD_in = 32'hA222_2222;
    tick();
    chk("t2_b2_d", bus.rd_data, 32'hA222_2222);
    chk1("t2_b3_frame", bus.FRAME_, 1'b1);
    chk1("t2_b3_irdy", bus.IRDY_, 1'b0);
    bus.AD_in = 32'hA333_3333;
    tick();
    chk1("t2_b3_v", bus.rd_valid, 1'b1);
    chk("t2_b3_d", bus.rd_data, 32'hA333_3333);
    chk1("t2_t_done", bus.done, 1'b1);
    chk1("t2_t_irdy", bus.IRDY_, 1'b1);
    bus.TRDY_ = 1'b1;
    bus.DEVSEL_ = 1'b1;
    tick();
    chk1("t2_i_v", bus.rd_valid, 1'b0);

    // 3: write of 3, DEVSEL_ never asserted
    wbase = nadv;
    req(4'h7, 32'h3000, 8'd3);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk1("t3_d1_irdy", bus.IRDY_, 1'b0);
    repeat (4) tick();
    chk1("t3_d5_frame", bus.FRAME_, 1'b0);
    chk1("t3_d5_irdy", bus.IRDY_, 1'b0);
    tick();
    chk1("t3_ab_frame", bus.FRAME_, 1'b1);
    chk1("t3_ab_irdy", bus.IRDY_, 1'b0);
    chk1("t3_ab_done", bus.done, 1'b0);
    tick();
    chk1("t3_t_done", bus.done, 1'b1);
    chk1("t3_t_err", bus.err, 1'b1);
    chk1("t3_t_irdy", bus.IRDY_, 1'b1);
    chk("t3_nadv", 32'(nadv - wbase), 32'd0);
    tick();
    chk1("t3_i_err", bus.err, 1'b0);

    // 4: zero length behaves as one beat
    wbase = nadv;
    bus.wbe = 4'hA;
    req(4'h3, 32'h4000, 8'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("t4_a_ad", bus.AD, 32'h4000);
    bus.TRDY_ = 1'b0;
    bus.DEVSEL_ = 1'b0;
    tick();
    chk1("t4_d_frame", bus.FRAME_, 1'b1);
    chk1("t4_d_irdy", bus.IRDY_, 1'b0);
    chk("t4_d_cbe", 32'(bus.C_BE_), 32'hA);
    tick();
    chk1("t4_t_done", bus.done, 1'b1);
    chk("t4_nadv", 32'(nadv - wbase), 32'd1);
    bus.TRDY_ = 1'b1;
    bus.DEVSEL_ = 1'b1;
    tick();

    // 5: reset during beat 2 of 4
    wbase = nadv;
    bus.wbe = 4'h0;
    req(4'h7, 32'h5000, 8'd4);
    tick();
    bus.req_valid = 1'b0;
    bus.TRDY_ = 1'b0;
    bus.DEVSEL_ = 1'b0;
    tick();
    chk("t5_b0_ad", bus.AD, 32'hD000_0000);
    tick();
    chk("t5_b1_ad", bus.AD, 32'hD000_0101);
    chk1("t5_b1_frame", bus.FRAME_, 1'b0);
    nd0 = ndone;
    #2 reset_ = 1'b0;
    #1;
    chk1("t5_r_frame", bus.FRAME_, 1'b1);
    chk1("t5_r_irdy", bus.IRDY_, 1'b1);
    chk("t5_r_cbe", 32'(bus.C_BE_), 32'hF);
    chk("t5_r_ad", bus.AD, 32'h0);
    bus.TRDY_ = 1'b1;
    bus.DEVSEL_ = 1'b1;
    tick();
    reset_ = 1'b1;
    tick();
    chk1("t5_rdy", bus.req_ready, 1'b1);
    tick();
    chk("t5_ndone", 32'(ndone - nd0), 32'd0);

    // 6: back-to-back single-beat writes
    wbase = nadv;
    bus.TRDY_ = 1'b0;
    bus.DEVSEL_ = 1'b0;
    req(4'h7, 32'h6000, 8'd1);
    tick();
    chk("t6_a1_ad", bus.AD, 32'h6000);
    bus.req_addr = 32'h7000;
    tick();
    chk("t6_d1_ad", bus.AD, 32'hD000_0000);
    tick();
    chk1("t6_t1_done", bus.done, 1'b1);
    tick();
    chk1("t6_i_frame", bus.FRAME_, 1'b1);
    chk1("t6_i_irdy", bus.IRDY_, 1'b1);
    chk1("t6_i_rdy", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    chk1("t6_a2_frame", bus.FRAME_, 1'b0);
    chk("t6_a2_ad", bus.AD, 32'h7000);
    tick();
    chk("t6_d2_ad", bus.AD, 32'hD000_0101);
    tick();
    chk1("t6_t2_done", bus.done, 1'b1);
    chk("t6_nadv", 32'(nadv - wbase), 32'd2);
    bus.TRDY_ = 1'b1;
    bus.DEVSEL_ = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
